// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared state enum and default width for serial_subtractor
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  localparam int SUB_DEFAULT_BITS = 8;

endpackage

// File: rtl/subtractor_1bit.sv
// rtl/subtractor_1bit.sv - combinational 1-bit full-subtractor cell (x - y - bin)
module subtractor_1bit (
  input  logic a,
  input  logic b,
  input  logic borrow_in,
  output logic diff,
  output logic borrow_out
);

  assign diff       = a ^ b ^ borrow_in;
  assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a-b, LSB first, start/done handshake
// Optional signed overflow output enabled by SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int NUM_BITS = SUB_DEFAULT_BITS
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] diff,
  output logic                borrow_out
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic                overflow
`endif
);

  localparam int CW = $clog2(NUM_BITS + 1);

  sub_state_t          state, next_state;
  logic [NUM_BITS-1:0] a_sh, b_sh, result;
  logic                borrow_q;
  logic [CW-1:0]       cnt;
  logic                cell_d, cell_bout;
  logic                load, shift, last_bit;

  assign last_bit = (cnt == CW'(1));

  subtractor_1bit u_cell (
    .a          (a_sh[0]),
    .b          (b_sh[0]),
    .borrow_in  (borrow_q),
    .diff       (cell_d),
    .borrow_out (cell_bout)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    shift      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          load       = 1'b1;
          next_state = BUSY;
        end else begin
          next_state = IDLE;
        end
      end
      BUSY: begin
        shift = 1'b1;
        if (last_bit) next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Result fills from the MSB end so after NUM_BITS shifts bit 0 lands at diff[0].
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      result   <= '0;
      borrow_q <= 1'b0;
      cnt      <= '0;
    end else if (load) begin
      a_sh     <= a;
      b_sh     <= b;
      result   <= '0;
      borrow_q <= 1'b0;
      cnt      <= CW'(NUM_BITS);
    end else if (shift) begin
      a_sh     <= a_sh >> 1;
      b_sh     <= b_sh >> 1;
      result   <= {cell_d, result[NUM_BITS-1:1]};
      borrow_q <= cell_bout;
      if (!last_bit) cnt <= cnt - 1'b1;
    end
  end

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic a_msb, b_msb, ovf_q;

  // The final cell output is the result MSB, so overflow is decided on the last bit.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf_q <= 1'b0;
    end else if (load) begin
      a_msb <= a[NUM_BITS-1];
      b_msb <= b[NUM_BITS-1];
      ovf_q <= 1'b0;
    end else if (shift && last_bit) begin
      ovf_q <= (a_msb ^ b_msb) & (cell_d ^ a_msb);
    end
  end

  assign overflow = ovf_q;
`endif

  assign busy       = (state == BUSY);
  assign done       = (state == DONE);
  assign diff       = result;
  assign borrow_out = borrow_q;

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor that computes `a - b` one bit per clock, LSB first. It uses a single borrow flip-flop and a 1-bit full-subtractor cell, which makes it the inverse-operation counterpart of the team's 1-bit adder cell. It sits beside the ripple adders in the datapath library as a low-area arithmetic unit behind a start/done handshake.

## Interface
Parameters:
- `NUM_BITS`, default 8: operand and result width; legal range ≥ 2.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `n_rst`  input  1  reset; asynchronous and active-low.
- `start`  input  1  request; sampled only when not busy.
- `a`  input  NUM_BITS  minuend; sampled with `start`.
- `b`  input  NUM_BITS  subtrahend; sampled with `start`.
- `busy`  output  1  high while bits are being processed.
- `done`  output  1  one-cycle pulse; result is valid from this cycle on.
- `diff`  output  NUM_BITS  `(a - b) mod 2^NUM_BITS`.
- `borrow_out`  output  1  final borrow; 1 exactly when `a < b` (unsigned).
- `overflow`  output  1  signed overflow; present only with `SERIAL_SUB_OVERFLOW_EN`.

## Operation
- States (shared enum): IDLE, BUSY, DONE.
- IDLE or DONE with `start`=1:
  - latch `a` and `b` into shift registers;
  - clear the borrow flip-flop and the result register;
  - load the bit counter with `NUM_BITS`;
  - go to BUSY.
- BUSY, each cycle:
  - the cell takes the LSBs of the shift registers and the current borrow;
  - its difference bit shifts into the MSB of the result register (right shift);
  - its borrow output is registered;
  - the counter decrements.
  - On the last bit (counter = 1), go to DONE.
- DONE lasts one cycle, then returns to IDLE unless `start`=1.
- `start` in BUSY is ignored; operands are not re-sampled.
- Cell equations:
  - `d = x ^ y ^ bin`
  - `bout = (~x & y) | (~(x ^ y) & bin)`
- `diff` and `borrow_out` are driven from registers. They hold their values through IDLE until the next accepted `start`, which clears them to 0.
- `busy` = (state == BUSY); `done` = (state == DONE). Both are registered-state decodes with no input paths.
- Counter width is `$clog2(NUM_BITS+1)`. There is no wrap: the counter never decrements below 1 in BUSY.

## Timing
- Reset value of every output is 0, and the state is IDLE.
- Assertion of `n_rst`=0 in any state clears all state immediately, including mid-operation. The operation is abandoned, no `done` is produced, and a fresh `start` is required.
- Cycle sequence for a start sampled high at edge k:
  - after edge k: `busy`=1;
  - edges k+1 … k+NUM_BITS process bits 0 … NUM_BITS-1;
  - after edge k+NUM_BITS: `busy`=0, `done`=1, `diff` and `borrow_out` final.
- Latency from start edge to `done` is NUM_BITS+1 edges, counting the start edge.
- Throughput: a `start` sampled in the DONE cycle begins a new operation at that edge, so `done` is never asserted two cycles in a row. Back-to-back operations take NUM_BITS+1 cycles each.
- Simultaneous `start` and the last BUSY bit: `start` is ignored.

## Configuration
- `SERIAL_SUB_OVERFLOW_EN` defined:
  - the `overflow` port exists, reset 0;
  - it is registered at the DONE transition as `(a[MSB] != b[MSB]) && (diff[MSB] != a[MSB])`, using the latched operand MSBs;
  - it holds until the next accepted `start`, which clears it.
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Package `serial_sub_pkg`:
  - state enum `sub_state_t` {IDLE, BUSY, DONE};
  - constant `SUB_DEFAULT_BITS` = 8.
- Sub-module `subtractor_1bit`: combinational full-subtractor cell with ports `a`, `b`, `borrow_in`, `diff`, `borrow_out`. Instantiated once.
- Top level holds the FSM, counter, shift registers, borrow flop and result register.

## Test plan
- Reset, then `a`=0x5A, `b`=0x23, `start` for 1 cycle. Required: `busy` for 8 cycles, then `done` for one cycle with `diff`=0x37 and `borrow_out`=0.
- `a`=0x10, `b`=0x20. Required: `diff`=0xF0, `borrow_out`=1. With the macro, also `overflow`=0.
- `a`=0x80, `b`=0x01. Required: `diff`=0x7F, `borrow_out`=0. With the macro, `overflow`=1.
- `start` pulsed mid-BUSY with new operands. Required: ignored; result still that of the first operation, with `done` exactly 9 edges after the first start.
- `n_rst` asserted at bit 4 of a run. Required: all outputs 0 at once and no `done`. Then `a`=0x00, `b`=0x00 gives `diff`=0x00, `borrow_out`=0.
- `start` held high across DONE with `a`=0xFF, `b`=0xFF, then `a`=0x00, `b`=0xFF. Required: `done` pulses 9 cycles apart, results 0x00/0 then 0x01/1.
